note_highlight_sched: RTL and testbench
=======================================

# note_highlight_sched

Scheduler between the synth's key-state vector and the VGA key-box plotter. It keeps a shadow copy of what is currently drawn for each of the 12 keys and scans round-robin for keys whose pressed state differs from that copy. For each mismatch it issues one draw request to the plotter: the highlight colour when the key is pressed, the key's rest colour when released. It waits for the plotter's done handshake, then commits the shadow bit. Only one draw is outstanding at a time, so a single plotter is shared across all keys.

## Interface

Parameters:
- `HI_COLOUR`, default 3'b110: colour drawn for a pressed key.
- `NAT_COLOUR`, default 3'b111: rest colour for natural keys (0,2,4,5,7,9,11).
- `SHP_COLOUR`, default 3'b000: rest colour for sharp keys (1,3,6,8,10).
- `TIMEOUT`, default 16'd2000: maximum cycles spent waiting for `iDone` before a draw is abandoned.

Ports:
- `iClock`, in, 1: sole clock, rising edge.
- `iResetn`, in, 1: reset, asynchronous, active-low.
- `iNotes`, in, 12: current key state, bit k = note k pressed; synchronous to `iClock`.
- `iDone`, in, 1: plotter finished the current box; single-cycle pulse or level.
- `oStart`, out, 1: one-cycle draw request to the plotter.
- `oNote`, out, 4: key index 0..11 for the current request.
- `oColour`, out, 3: colour for the current request.
- `oBusy`, out, 1: high while a request is outstanding.
- `oErr`, out, 1: sticky timeout flag; cleared only by reset.
- `oState`, out, 3: current FSM state encoding, for debug.

## Operation

Internal state:
- `shown[11:0]`: shadow copy of what is drawn; bit k = highlight currently drawn for key k.
- `ptr[3:0]`: scan pointer, range 0..11.
- `wcnt[15:0]`: wait counter.

FSM states and encodings:
- SCAN (0): if `iNotes[ptr] != shown[ptr]`, latch `oNote=ptr` and the target colour, then go to ISSUE. Otherwise advance `ptr` (11 wraps to 0) and stay in SCAN.
- ISSUE (1): `oStart=1` for exactly this cycle; clear `wcnt`; go to WAIT.
- WAIT (2): if `iDone`, go to COMMIT. Else if `wcnt == TIMEOUT-1`, set `oErr`, advance `ptr`, and go to SCAN without committing. Else increment `wcnt`.
- COMMIT (3): set `shown[oNote]` to the value latched at SCAN; advance `ptr`; go to SCAN.
- CLEAR (4): exists only under the configuration macro (see Configuration).

Target colour selection:
- `HI_COLOUR` if the key was pressed at the SCAN detection cycle.
- Otherwise `SHP_COLOUR` for sharp keys, `NAT_COLOUR` for natural keys.

Behaviour rules:
- `iNotes` changes during ISSUE/WAIT do not alter the in-flight request. The shadow commits the value latched at SCAN; any remaining difference is redrawn on a later pass.
- A key pressed and released between scans of that key produces no draw.
- Simultaneous changes are served in pointer order starting from the current `ptr`. Worst-case service delay for any key is 12 draws plus 12 scan cycles.
- After a timeout the key stays mismatched and is re-issued on the next pass.
- `iDone` is ignored outside WAIT.
- `ptr` never holds 12..15.

## Timing

- Reset values: `oStart=0`, `oNote=0`, `oColour=0`, `oBusy=0`, `oErr=0`, `oState=0`, `shown=0`, `ptr=0`, `wcnt=0`. The state is SCAN, or CLEAR when the macro is defined.
- Reset asserted mid-WAIT aborts the request immediately. `oStart` and `oBusy` drop asynchronously, and no commit takes place.
- Draw latency, for a mismatch detected at SCAN in cycle t:
  - `oStart=1` in cycle t+1, with `oNote` and `oColour` valid.
  - WAIT begins at t+2.
  - `iDone` sampled in cycle d gives COMMIT at d+1 and SCAN at d+2 with `ptr+1`.
- `oNote` and `oColour` are registered, updated at the SCAN→ISSUE transition, and held stable until the next ISSUE.
- `oBusy` is high during ISSUE, WAIT and COMMIT, and during all of CLEAR.
- Scan rate: one key per cycle while idle, so a full idle pass takes 12 cycles.
- Timeout: WAIT exits to SCAN exactly `TIMEOUT` cycles after entry when `iDone` never arrives. `oErr` is high from the following cycle.

## Configuration

- `NOTE_SCHED_CLEAR_EN` defined:
  - After reset, the FSM enters CLEAR.
  - CLEAR issues one ISSUE/WAIT sequence for each of keys 0..11 in order, using rest colours. The same timeout rule applies.
  - It then enters SCAN with `shown=0` and `ptr=0`.
  - Result: the keyboard image is repainted to a known state at power-up.
- `NOTE_SCHED_CLEAR_EN` undefined:
  - The CLEAR state and its logic are absent.
  - The FSM starts in SCAN, and the screen is assumed pre-drawn.

## Test plan

- Macro off; reset; hold `iNotes=0` for 200 cycles → `oStart` never asserts, `oBusy=0`, `oErr=0`.
- `iNotes=12'h001`; plotter pulses `iDone` 16 cycles after `oStart` → one `oStart` with `oNote=0`, `oColour=3'b110`. Then drop to `iNotes=0` → one `oStart` with `oNote=0`, `oColour=3'b111`.
- Press then release key 1 (sharp) → release draw has `oNote=1`, `oColour=3'b000`.
- With `ptr` at 5, set `iNotes` bits 3 and 10 together → requests in order `oNote=10`, then `oNote=3`, each preceded by its `iDone`.
- `iNotes=12'h010`, `iDone` never asserted, `TIMEOUT=100` → `oErr=1` at cycle 101 after WAIT entry. A second `oStart` with `oNote=4` follows on the next pass. Assert `iResetn=0` mid-WAIT → all outputs 0 immediately, and no commit.
- Macro on; reset → 12 `oStart` pulses with `oNote=0..11` and rest colours (`3'b000` for keys 1,3,6,8,10, `3'b111` otherwise), then idle in SCAN with `oBusy=0`.

Source files
------------

// File: rtl/note_highlight_sched_if.sv
// ============================================================================
// note_highlight_sched_if : plotter draw-request handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface note_highlight_sched_if;
  logic       oStart;
  logic [3:0] oNote;
  logic [2:0] oColour;
  logic       oBusy;
  logic       iDone;

  modport master (output oStart, output oNote, output oColour, output oBusy, input iDone);
  modport slave  (input oStart, input oNote, input oColour, input oBusy, output iDone);
endinterface

`default_nettype wire

// File: rtl/note_highlight_sched.sv
// ============================================================================
// note_highlight_sched : round-robin key-highlight redraw scheduler, one
// outstanding plotter request at a time. Optional power-up repaint: NOTE_SCHED_CLEAR_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module note_highlight_sched #(
  parameter logic [2:0]  HI_COLOUR  = 3'b110,
  parameter logic [2:0]  NAT_COLOUR = 3'b111,
  parameter logic [2:0]  SHP_COLOUR = 3'b000,
  parameter logic [15:0] TIMEOUT    = 16'd2000
) (
  input  wire logic               iClock,
  input  wire logic               iResetn,
  input  wire logic [11:0]        iNotes,
  note_highlight_sched_if.master  plot,
  output logic                    oErr,
  output logic [2:0]              oState
);

  typedef enum logic [2:0] {
    ST_SCAN   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_CLEAR  = 3'd4
  } state_t;

  // Sharp keys 1,3,6,8,10
  localparam logic [11:0] C_SHARP_MASK = 12'h54A;

`ifdef NOTE_SCHED_CLEAR_EN
  localparam state_t C_RESET_STATE = ST_CLEAR;
`else
  localparam state_t C_RESET_STATE = ST_SCAN;
`endif

  state_t      state_q, state_d;
  logic [11:0] shown_q, shown_d;
  logic [3:0]  ptr_q, ptr_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [3:0]  note_q, note_d;
  logic [2:0]  colour_q, colour_d;
  logic        val_q, val_d;
  logic        err_q, err_d;
`ifdef NOTE_SCHED_CLEAR_EN
  logic        clr_q, clr_d;
`endif

  function automatic logic [3:0] next_ptr(input logic [3:0] p);
    return (p == 4'd11) ? 4'd0 : p + 4'd1;
  endfunction

  function automatic logic [2:0] rest_colour(input logic [3:0] k);
    return C_SHARP_MASK[k] ? SHP_COLOUR : NAT_COLOUR;
  endfunction

  always_comb begin
    state_d  = state_q;
    shown_d  = shown_q;
    ptr_d    = ptr_q;
    wcnt_d   = wcnt_q;
    note_d   = note_q;
    colour_d = colour_q;
    val_d    = val_q;
    err_d    = err_q;
`ifdef NOTE_SCHED_CLEAR_EN
    clr_d    = clr_q;
`endif
    case (state_q)
      ST_SCAN: begin
        if (iNotes[ptr_q] != shown_q[ptr_q]) begin
          note_d   = ptr_q;
          val_d    = iNotes[ptr_q];
          colour_d = iNotes[ptr_q] ? HI_COLOUR : rest_colour(ptr_q);
          state_d  = ST_ISSUE;
        end else begin
          ptr_d = next_ptr(ptr_q);
        end
      end
      ST_ISSUE: begin
        wcnt_d  = 16'd0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (plot.iDone || (wcnt_q == TIMEOUT - 16'd1)) begin
          if (!plot.iDone)
            err_d = 1'b1;
`ifdef NOTE_SCHED_CLEAR_EN
          // Repaint draws never commit; shadow is forced to 0 once done
          if (clr_q) begin
            if (ptr_q == 4'd11) begin
              ptr_d   = 4'd0;
              shown_d = 12'd0;
              clr_d   = 1'b0;
              state_d = ST_SCAN;
            end else begin
              ptr_d   = ptr_q + 4'd1;
              state_d = ST_CLEAR;
            end
          end else
`endif
          if (plot.iDone) begin
            state_d = ST_COMMIT;
          end else begin
            ptr_d   = next_ptr(ptr_q);
            state_d = ST_SCAN;
          end
        end else begin
          wcnt_d = wcnt_q + 16'd1;
        end
      end
      ST_COMMIT: begin
        shown_d[note_q] = val_q;
        ptr_d           = next_ptr(ptr_q);
        state_d         = ST_SCAN;
      end
`ifdef NOTE_SCHED_CLEAR_EN
      ST_CLEAR: begin
        note_d   = ptr_q;
        val_d    = 1'b0;
        colour_d = rest_colour(ptr_q);
        state_d  = ST_ISSUE;
      end
`endif
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge iClock or negedge iResetn) begin
    if (!iResetn) begin
      state_q  <= C_RESET_STATE;
      shown_q  <= 12'd0;
      ptr_q    <= 4'd0;
      wcnt_q   <= 16'd0;
      note_q   <= 4'd0;
      colour_q <= 3'd0;
      val_q    <= 1'b0;
      err_q    <= 1'b0;
`ifdef NOTE_SCHED_CLEAR_EN
      clr_q    <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      shown_q  <= shown_d;
      ptr_q    <= ptr_d;
      wcnt_q   <= wcnt_d;
      note_q   <= note_d;
      colour_q <= colour_d;
      val_q    <= val_d;
      err_q    <= err_d;
`ifdef NOTE_SCHED_CLEAR_EN
      clr_q    <= clr_d;
`endif
    end
  end

  // Decoded from the state flop so reset drops them without waiting for a clock
  assign plot.oStart  = (state_q == ST_ISSUE);
  assign plot.oBusy   = (state_q != ST_SCAN);
  assign plot.oNote   = note_q;
  assign plot.oColour = colour_q;
  assign oErr         = err_q;
  assign oState       = state_q;

endmodule

`default_nettype wire

// File: tb/tb_note_highlight_sched.sv
// ============================================================================
// tb_note_highlight_sched : scoreboard bench for note_highlight_sched
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_note_highlight_sched;

  typedef struct packed {
    logic [3:0] note;
    logic [2:0] col;
  } draw_t;

  logic        clk;
  logic        rst_n;
  logic [11:0] notes;
  logic        err;
  logic [2:0]  state;
  logic        plot_en;

  draw_t exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;
  int    n_start = 0;

  note_highlight_sched_if plot_if ();

  note_highlight_sched #(
    .HI_COLOUR  (3'b110),
    .NAT_COLOUR (3'b111),
    .SHP_COLOUR (3'b000),
    .TIMEOUT    (16'd100)
  ) dut (
    .iClock  (clk),
    .iResetn (rst_n),
    .iNotes  (notes),
    .plot    (plot_if.master),
    .oErr    (err),
    .oState  (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef NOTE_SCHED_CLEAR_EN
  localparam logic [2:0] C_RST_STATE = 3'd4;
  localparam logic       C_RST_BUSY  = 1'b1;
`else
  localparam logic [2:0] C_RST_STATE = 3'd0;
  localparam logic       C_RST_BUSY  = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, expv);
  endtask

  task automatic push(input logic [3:0] n, input logic [2:0] c);
    exp_q.push_back('{note: n, col: c});
  endtask

  task automatic push_clear();
`ifdef NOTE_SCHED_CLEAR_EN
    logic [2:0] rest_tbl [12] = '{3'b111, 3'b000, 3'b111, 3'b000, 3'b111, 3'b111,
                                  3'b000, 3'b111, 3'b000, 3'b111, 3'b000, 3'b111};
    for (int k = 0; k < 12; k++) push(4'(k), rest_tbl[k]);
`endif
  endtask

  // Wait until every expected draw has been seen and the scheduler is idle again
  task automatic drain(input string name, input int limit);
    int n = 0;
    while (!(exp_q.size() == 0 && !plot_if.oBusy) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < limit), 32'd1);
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int limit);
    int n = 0;
    while (state !== s && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(state), 32'(s));
  endtask

  // Plotter model: acknowledge each request 16 cycles later
  initial begin
    plot_if.iDone = 1'b0;
    forever begin
      @(negedge clk);
      if (plot_en && plot_if.oStart) begin
        repeat (16) @(negedge clk);
        plot_if.iDone = 1'b1;
        @(negedge clk);
        plot_if.iDone = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && plot_if.oStart) begin
        draw_t e;
        n_start++;
        n_total++;
        if (exp_q.size() == 0) begin
          $display("FAIL draw: unexpected note=%0d colour=%b", plot_if.oNote, plot_if.oColour);
        end else begin
          e = exp_q.pop_front();
          if (plot_if.oNote === e.note && plot_if.oColour === e.col) n_pass++;
          else $display("FAIL draw: note=%0d colour=%b, expected note=%0d colour=%b",
                        plot_if.oNote, plot_if.oColour, e.note, e.col);
        end
      end
    end
  end

  initial begin
    int   s0;
    int   n;
    logic busy_seen;

    rst_n   = 1'b0;
    notes   = 12'h000;
    plot_en = 1'b1;
    #3;
    check("rst_start",  32'(plot_if.oStart),  32'd0);
    check("rst_note",   32'(plot_if.oNote),   32'd0);
    check("rst_colour", 32'(plot_if.oColour), 32'd0);
    check("rst_busy",   32'(plot_if.oBusy),   32'(C_RST_BUSY));
    check("rst_err",    32'(err),             32'd0);
    check("rst_state",  32'(state),           32'(C_RST_STATE));
    push_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drain("clear_drain", 3000);

    // Idle: nothing may be drawn
    s0 = n_start;
    busy_seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      busy_seen |= plot_if.oBusy;
    end
    check("idle_starts", 32'(n_start - s0), 32'd0);
    check("idle_busy",   32'(busy_seen),    32'd0);
    check("idle_err",    32'(err),          32'd0);

    notes = 12'h001; push(4'd0, 3'b110); drain("k0_press", 500);
    notes = 12'h000; push(4'd0, 3'b111); drain("k0_release", 500);
    notes = 12'h002; push(4'd1, 3'b110); drain("k1_press", 500);
    notes = 12'h000; push(4'd1, 3'b000); drain("k1_release", 500);

    // Key 4 leaves ptr at 5, then 3 and 10 arrive together
    notes = 12'h010; push(4'd4, 3'b110);
    wait_state("k4_wait", 3'd2, 100);
    notes = 12'h418; push(4'd10, 3'b110); push(4'd3, 3'b110);
    drain("multi_press", 1000);
    notes = 12'h000; push(4'd4, 3'b111); push(4'd10, 3'b000); push(4'd3, 3'b000);
    drain("multi_release", 1000);

    // Timeout with silent plotter
    plot_en = 1'b0;
    notes = 12'h010; push(4'd4, 3'b110);
    wait_state("to_wait", 3'd2, 100);
    check("to_err_before", 32'(err), 32'd0);
    n = 0;
    while (state === 3'd2 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("to_cycles",    32'(n),     32'd100);
    check("to_err_after", 32'(err),   32'd1);
    check("to_state",     32'(state), 32'd0);

    // Re-issue on next pass, then reset mid-WAIT
    push(4'd4, 3'b110);
    wait_state("reissue_wait", 3'd2, 100);
    check("reissue_seen", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_start", 32'(plot_if.oStart), 32'd0);
    check("arst_busy",  32'(plot_if.oBusy),  32'(C_RST_BUSY));
    check("arst_err",   32'(err),            32'd0);
    check("arst_state", 32'(state),          32'(C_RST_STATE));
    check("arst_note",  32'(plot_if.oNote),  32'd0);
    plot_en = 1'b1;
    push_clear();
    push(4'd4, 3'b110);
    @(negedge clk);
    rst_n = 1'b1;
    drain("no_commit_redraw", 3000);
    repeat (30) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
